// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data memory.
//
// Port 0 is the CPU datapath, port 1 the loader/debug path. A request is
// sampled only while the arbiter is idle; the winner's command is latched and
// issued to memory for exactly one cycle (gntN pulse). Reads then spend one
// more cycle collecting the synchronous memory data (rvalidN pulse).
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   reqN_i, wrN_i              per-port request and direction (1 = write)
//   addrN_i, wdataN_i          per-port address and write data
//   gntN_o                     command for port N issued this cycle
//   rvalidN_o                  rdata_o carries port N's read data this cycle
//   rdata_o                    shared read data (valid only with rvalidN_o)
//   stall0_o                   CPU hold: req0_i high without gnt0_o
//   mem_write_o, mem_addr_o,
//   mem_wdata_o                memory-side command
//   mem_rdata_i                memory read data, one cycle after the address
module mem_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned D_ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic                wr0_i,
  input  logic                wr1_i,
  input  logic [D_ADDR_W-1:0] addr0_i,
  input  logic [D_ADDR_W-1:0] addr1_i,
  input  logic [WIDTH-1:0]    wdata0_i,
  input  logic [WIDTH-1:0]    wdata1_i,
  output logic                gnt0_o,
  output logic                gnt1_o,
  output logic                rvalid0_o,
  output logic                rvalid1_o,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                stall0_o,
  output logic                mem_write_o,
  output logic [D_ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]    mem_wdata_o,
  input  logic [WIDTH-1:0]    mem_rdata_i
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e                state_q;
  logic                  last_gnt_q;  // port granted most recently
  logic                  win_q;       // port owning the transaction in flight
  logic                  wr_q;
  logic [D_ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic                  mem_write_q;

  // Arbitration decision for the current idle cycle.
  logic                  any_req;
  logic                  win_d;
  logic                  wr_d;
  logic [D_ADDR_W-1:0]   addr_d;
  logic [WIDTH-1:0]      wdata_d;

  always_comb begin
    any_req = req0_i | req1_i;
    // Contested: the port that did not win last time. Uncontested: whoever asks.
    if (req0_i && req1_i) begin
      win_d = ~last_gnt_q;
    end else begin
      win_d = req1_i;
    end
    wr_d    = win_d ? wr1_i    : wr0_i;
    addr_d  = win_d ? addr1_i  : addr0_i;
    wdata_d = win_d ? wdata1_i : wdata0_i;
  end

  // Single FSM process; every output pulse is registered so it is glitch-free
  // and cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      // Pulses default low; each state raises only what it owns.
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            win_q       <= win_d;
            last_gnt_q  <= win_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
            mem_write_q <= wr_d;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (wr_q) begin
            state_q <= StIdle;
          end else begin
            // Memory samples the address at this edge; data is valid in StResp.
            rvalid0_q <= ~win_q;
            rvalid1_q <= win_q;
            state_q   <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign mem_write_o = mem_write_q;
  // The latched command doubles as the memory command; it only changes when a
  // new request is accepted, so the address holds between transactions.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = mem_rdata_i;
  assign stall0_o    = req0_i & ~gnt0_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned D_ADDR_W = 8;

  logic                clk;
  logic                rst_n;
  logic                req0, req1, wr0, wr1;
  logic [D_ADDR_W-1:0] addr0, addr1;
  logic [WIDTH-1:0]    wdata0, wdata1;
  logic                gnt0, gnt1, rvalid0, rvalid1, stall0, mem_write;
  logic [WIDTH-1:0]    rdata, mem_wdata, mem_rdata;
  logic [D_ADDR_W-1:0] mem_addr;
  logic                mem_init;

  mem_arbiter #(.WIDTH(WIDTH), .D_ADDR_W(D_ADDR_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_i      (req0),
    .req1_i      (req1),
    .wr0_i       (wr0),
    .wr1_i       (wr1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1),
    .rdata_o     (rdata),
    .stall0_o    (stall0),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] init_val(int i);
    logic [7:0] a;
    a = i[7:0];
    return {a ^ 8'hA5, a};
  endfunction

  // Environment memory: synchronous read, registered data one cycle later.
  logic [WIDTH-1:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else if (mem_write) begin
      env_mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= env_mem[mem_addr];
  end

  // Reference model: one transaction object with a start edge; outputs follow
  // from its age (edges since it was accepted) and kind.
  int                  n_cmp = 0;
  int                  n_bad = 0;
  int                  edge_n = 0;
  bit                  t_act;
  int                  t_t0;
  bit                  t_port, t_wr;
  logic [D_ADDR_W-1:0] t_addr;
  logic [WIDTH-1:0]    t_wdata;
  bit                  last_win;
  logic [D_ADDR_W-1:0] m_addr;
  logic [WIDTH-1:0]    ref_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t_act    = 1'b0;
    last_win = 1'b1;
    m_addr   = '0;
  endtask

  task automatic model_edge();
    int age;
    edge_n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (t_act) begin
      age = edge_n - t_t0;
      if (age == 1 && t_wr) ref_mem[t_addr] = t_wdata;
      if (age >= (t_wr ? 2 : 3)) t_act = 1'b0;
    end
    if (!t_act && (req0 || req1)) begin
      t_port   = (req0 && req1) ? !last_win : req1;
      t_wr     = t_port ? wr1 : wr0;
      t_addr   = t_port ? addr1 : addr0;
      t_wdata  = t_port ? wdata1 : wdata0;
      t_t0     = edge_n;
      t_act    = 1'b1;
      last_win = t_port;
      m_addr   = t_addr;
    end
  endtask

  task automatic compare();
    int age;
    bit eg0, eg1, erv0, erv1, emw;
    age  = edge_n - t_t0;
    eg0  = t_act && age == 0 && !t_port;
    eg1  = t_act && age == 0 && t_port;
    emw  = t_act && age == 0 && t_wr;
    erv0 = t_act && age == 1 && !t_wr && !t_port;
    erv1 = t_act && age == 1 && !t_wr && t_port;
    chk("gnt0", {31'b0, gnt0}, {31'b0, eg0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, eg1});
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, erv0});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, erv1});
    chk("mem_write", {31'b0, mem_write}, {31'b0, emw});
    chk("mem_addr", {24'b0, mem_addr}, {24'b0, m_addr});
    chk("stall0", {31'b0, stall0}, {31'b0, (req0 & !eg0)});
    if (emw) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, t_wdata});
    if (erv0 || erv1) chk("rdata", {16'b0, rdata}, {16'b0, ref_mem[t_addr]});
  endtask

  // Inputs change at the falling edge, right after the outputs are checked.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0;
  endtask

  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    for (int i = 0; i < hold; i++) tick();
    rst_n = 1'b1;
  endtask

  int  gq[$];
  int  cnt;

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    t_t0 = 0; t_port = 0; t_wr = 0; t_addr = '0; t_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    tick();
    mem_init = 1'b0;
    tick();
    // Reset state
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    // Both ports read continuously for 12 cycles: grants alternate from port 0.
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 8'h05; addr1 = 8'h06;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt0) gq.push_back(0);
      if (gnt1) gq.push_back(1);
    end
    chk("alt_count", gq.size(), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("alt_order", gq[i], i % 2);
    idle_inputs();
    tick(); tick(); tick();

    // Lone port-0 write.
    req0 = 1; wr0 = 1; addr0 = 8'h10; wdata0 = 16'hBEEF;
    tick();
    chk("w_gnt0", {31'b0, gnt0}, 32'd1);
    chk("w_mem_write", {31'b0, mem_write}, 32'd1);
    chk("w_mem_addr", {24'b0, mem_addr}, 32'h10);
    chk("w_mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
    idle_inputs();
    tick();
    chk("w_done_write", {31'b0, mem_write}, 32'd0);

    // Store 0x1234 at 0x22, then read it back through port 1.
    req0 = 1; wr0 = 1; addr0 = 8'h22; wdata0 = 16'h1234;
    tick();
    idle_inputs();
    tick();
    req1 = 1; wr1 = 0; addr1 = 8'h22;
    tick();
    chk("r_gnt1", {31'b0, gnt1}, 32'd1);
    idle_inputs();
    tick();
    chk("r_rvalid1", {31'b0, rvalid1}, 32'd1);
    chk("r_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("r_rdata", {16'b0, rdata}, 32'h1234);
    tick();

    // Fairness after each winner.
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0;
    tick();
    chk("after1_gnt0", {31'b0, gnt0}, 32'd1);
    idle_inputs();
    tick(); tick();
    req0 = 1; req1 = 1;
    tick();
    chk("after0_gnt1", {31'b0, gnt1}, 32'd1);
    idle_inputs();
    tick(); tick();

    // Port 1 pulses its request only while port 0's write is in flight.
    req0 = 1; wr0 = 1; addr0 = 8'h31; wdata0 = 16'h0F0F;
    tick();
    req0 = 0; req1 = 1; wr1 = 1; addr1 = 8'h32; wdata1 = 16'h7777;
    cnt = 0;
    tick();
    if (gnt1) cnt++;
    req1 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt1) cnt++;
    end
    chk("withdrawn_gnt1", cnt, 32'd0);

    // Reset in the access cycle of a write aborts it.
    req0 = 1; wr0 = 1; addr0 = 8'h40; wdata0 = 16'hCAFE;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort_gnt0", {31'b0, gnt0}, 32'd0);
    rst_n = 1'b1;
    async_reset(2);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt0 || gnt1 || rvalid0 || rvalid1) cnt++;
    end
    chk("abort_no_pulse", cnt, 32'd0);
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 8'h40; addr1 = 8'h41;
    tick();
    chk("abort_last_gnt", {31'b0, gnt0}, 32'd1);
    idle_inputs();
    tick();
    chk("abort_not_written", {16'b0, rdata}, {16'b0, init_val(8'h40)});
    tick();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset($urandom_range(1, 2));
      end else begin
        req0   = ($urandom_range(0, 99) < 55);
        req1   = ($urandom_range(0, 99) < 45);
        wr0    = $urandom_range(0, 1);
        wr1    = $urandom_range(0, 1);
        addr0  = 8'($urandom_range(0, 15));
        addr1  = 8'($urandom_range(0, 15));
        wdata0 = 16'($urandom);
        wdata1 = 16'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter D_ADDR_W, default 8, data memory address width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  access request; port 0 = CPU datapath, port 1 = loader/debug.
REQ-006 wr0, wr1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0, addr1  input  D_ADDR_W each  access address.
REQ-008 wdata0, wdata1  input  WIDTH each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; the port's access is being issued this cycle.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-011 rdata  output  WIDTH  read data shared by both ports; meaningful only while rvalid0 or rvalid1 is high.
REQ-012 stall0  output  1  high while req0 is high and gnt0 is low (CPU hold).
REQ-013 mem_write, mem_addr[D_ADDR_W], mem_wdata[WIDTH]  output  memory-side command.
REQ-014 mem_rdata  input  WIDTH  synchronous memory read data, valid one cycle after the address is presented.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP.
REQ-016 IDLE: at a clock edge with req0 or req1 high, select a winner, latch its wr/addr/wdata into internal registers and move to ACCESS; with no request, stay in IDLE.
REQ-017 Single request: the requesting port wins.
REQ-018 Both requests: the port other than last_gnt wins; last_gnt then updates to the winner.
REQ-019 last_gnt resets to 1, so port 0 wins the first contested arbitration.
REQ-020 ACCESS: gntN = 1 for the winner only; mem_addr and mem_wdata come from the latched registers; mem_write = latched wr.
REQ-021 ACCESS exit: a write returns to IDLE; a read moves to RESP.
REQ-022 RESP: rvalidN = 1 for the winner; rdata = mem_rdata; mem_write = 0; next state IDLE.
REQ-023 Latency from the request-sampling edge: write completes (gnt) in 1 cycle; read data arrives 2 cycles later. Back-to-back throughput: write 1 per 2 cycles, read 1 per 3 cycles.
REQ-024 req is level-sensitive and sampled only in IDLE; a requester drops req in the cycle after seeing gnt, otherwise a new transaction follows.
REQ-025 Changes to req, wr, addr or wdata outside IDLE have no effect on the transaction in flight.
REQ-026 A request withdrawn before it is sampled is never granted.
REQ-027 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 is high in any cycle; gnt and rvalid are never high in the same cycle.
REQ-028 mem_write is high only in ACCESS with a latched write.
REQ-029 Outside ACCESS and RESP: mem_addr holds its last value; rdata is don't-care.

Reset
REQ-030 reset low forces, immediately and asynchronously: state IDLE, last_gnt = 1, latched registers = 0, all gnt/rvalid = 0, mem_write = 0.
REQ-031 Reset asserted mid-transaction aborts it; no gnt or rvalid is issued for it after release.
REQ-032 After reset deasserts, the first sampling edge arbitrates normally.

Verification
REQ-033 req0 write, addr 0x10, data 0xBEEF, alone -> next cycle gnt0 = 1, mem_write = 1, mem_addr = 0x10, mem_wdata = 0xBEEF; then IDLE.
REQ-034 Mem[0x22] = 0x1234; req1 read, addr 0x22 -> gnt1 in cycle+1, rvalid1 = 1 with rdata = 0x1234 in cycle+2, rvalid0 = 0.
REQ-035 req0 and req1 both held high for 12 cycles, all reads -> grant order 0,1,0,1; stall0 high in every cycle without gnt0.
REQ-036 After a port-1 grant, both request -> port 0 wins; after a port-0 grant, both request -> port 1 wins.
REQ-037 reset pulled low during the ACCESS cycle of a write -> mem_write drops at once, no gnt afterward, FSM in IDLE with last_gnt = 1 on release.
REQ-038 req1 raised and dropped entirely while the FSM is in ACCESS serving port 0 -> port 1 is never granted.
